// File: rtl/sha256_mem_arbiter.sv
// sha256_mem_arbiter: round-robin share of one memory read port among SHA-256 lanes.
// Define ARB_LOCK_EN to keep granting one lane while it requests (capped at 16).
module sha256_mem_arbiter #(
    parameter int N_REQ           = 4,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [N_REQ-1:0]                  req_addr_vld,
    input  logic [N_REQ*32-1:0]               req_addr,
    output logic [N_REQ-1:0]                  req_addr_rdy,
    output logic [N_REQ-1:0]                  req_data_vld,
    output logic [31:0]                       req_data,
    output logic                              mem_addr_vld,
    input  logic                              mem_addr_rdy,
    output logic [31:0]                       mem_addr,
    input  logic                              mem_data_vld,
    input  logic [31:0]                       mem_data,
    output logic [$clog2(MAX_OUTSTANDING):0]  outstanding,
    output logic                              err_unexpected_rsp
);
    localparam int LW = $clog2(N_REQ);
    localparam int PW = $clog2(MAX_OUTSTANDING);
    localparam int CW = PW + 1;

    logic [LW-1:0] last_grant;
    logic [LW-1:0] next_lane;
    logic [LW-1:0] scan_start;
    logic [LW-1:0] grant_lane;
    logic [LW:0]   idx;
    logic          addr_full;
    logic          stage_free;
    logic          can_grant;
    logic          grant;
    logic          rsp_hit;

    logic [LW-1:0] tag_mem [MAX_OUTSTANDING];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;

    assign stage_free   = !addr_full || mem_addr_rdy;
    assign can_grant    = stage_free && (count < CW'(MAX_OUTSTANDING));
    assign next_lane    = (last_grant == LW'(N_REQ - 1)) ? '0 : last_grant + LW'(1);
    assign rsp_hit      = mem_data_vld && (count != '0);
    assign mem_addr_vld = addr_full;
    assign outstanding  = count;

`ifdef ARB_LOCK_EN
    logic       locked;
    logic [4:0] run_len;

    // A locked lane is scanned first until the fairness cap is reached.
    assign scan_start = (locked && run_len < 5'd16) ? last_grant : next_lane;

    always_ff @(posedge clk) begin
        if (rst) begin
            locked  <= 1'b0;
            run_len <= '0;
        end else if (grant) begin
            locked <= 1'b1;
            if (locked && grant_lane == last_grant && run_len < 5'd16)
                run_len <= run_len + 5'd1;
            else
                run_len <= 5'd1;
        end else if (stage_free && !req_addr_vld[last_grant]) begin
            locked <= 1'b0;
        end
    end
`else
    assign scan_start = next_lane;
`endif

    always_comb begin
        grant      = 1'b0;
        grant_lane = '0;
        idx        = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = {1'b0, scan_start} + (LW+1)'(k);
            if (idx >= (LW+1)'(N_REQ))
                idx = idx - (LW+1)'(N_REQ);
            if (can_grant && !grant && req_addr_vld[idx[LW-1:0]]) begin
                grant      = 1'b1;
                grant_lane = idx[LW-1:0];
            end
        end
    end

    always_comb begin
        req_addr_rdy = '0;
        if (grant)
            req_addr_rdy[grant_lane] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_full  <= 1'b0;
            mem_addr   <= '0;
            last_grant <= LW'(N_REQ - 1);
        end else if (grant) begin
            addr_full  <= 1'b1;
            mem_addr   <= req_addr[grant_lane*32 +: 32];
            last_grant <= grant_lane;
        end else if (mem_addr_rdy) begin
            addr_full <= 1'b0;
        end
    end

    // Tag FIFO: count doubles as the outstanding-read counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (grant)
                wr_ptr <= wr_ptr + PW'(1);
            if (rsp_hit)
                rd_ptr <= rd_ptr + PW'(1);
            case ({grant, rsp_hit})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (grant)
            tag_mem[wr_ptr] <= grant_lane;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            req_data_vld       <= '0;
            req_data           <= '0;
            err_unexpected_rsp <= 1'b0;
        end else begin
            req_data_vld <= '0;
            if (rsp_hit) begin
                req_data_vld[tag_mem[rd_ptr]] <= 1'b1;
                req_data                      <= mem_data;
            end
            if (mem_data_vld && count == '0)
                err_unexpected_rsp <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sha256_mem_arbiter.sv
// tb_sha256_mem_arbiter: queue-based reference model with per-cycle compare,
// plus directed scenarios with literal expectations.
module tb_sha256_mem_arbiter;
    localparam int N    = 4;
    localparam int MAXO = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req_addr_vld = '0;
    logic [N*32-1:0] req_addr = '0;
    logic [N-1:0]    req_addr_rdy;
    logic [N-1:0]    req_data_vld;
    logic [31:0]     req_data;
    logic            mem_addr_vld;
    logic            mem_addr_rdy = 1'b0;
    logic [31:0]     mem_addr;
    logic            mem_data_vld = 1'b0;
    logic [31:0]     mem_data = '0;
    logic [3:0]      outstanding;
    logic            err;

    sha256_mem_arbiter #(.N_REQ(N), .MAX_OUTSTANDING(MAXO)) dut (
        .clk(clk), .rst(rst),
        .req_addr_vld(req_addr_vld), .req_addr(req_addr),
        .req_addr_rdy(req_addr_rdy),
        .req_data_vld(req_data_vld), .req_data(req_data),
        .mem_addr_vld(mem_addr_vld), .mem_addr_rdy(mem_addr_rdy),
        .mem_addr(mem_addr),
        .mem_data_vld(mem_data_vld), .mem_data(mem_data),
        .outstanding(outstanding), .err_unexpected_rsp(err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, want, $time);
        end
    endtask

    // Reference model state
    int           q[$];
    int           glog[$];
    int           rlog[$];
    logic [31:0]  dlog[$];
    bit           m_full = 0;
    logic [31:0]  m_addr = '0;
    int           last = N - 1;
    bit           m_lock = 0;
    int           run_len = 0;
    logic [N-1:0] e_dv = '0;
    logic [31:0]  e_d = '0;
    bit           e_err = 0;

    always @(negedge clk) begin
        bit           free;
        int           start;
        int           g;
        int           t;
        logic [N-1:0] e_rdy;
        free  = !m_full || mem_addr_rdy;
        start = (last + 1) % N;
`ifdef ARB_LOCK_EN
        if (m_lock && run_len < 16)
            start = last;
`endif
        g = -1;
        if (free && q.size() < MAXO)
            for (int k = 0; k < N; k++)
                if (g < 0 && req_addr_vld[(start + k) % N])
                    g = (start + k) % N;
        e_rdy = '0;
        if (g >= 0)
            e_rdy[g] = 1'b1;
        if (!rst) begin
            chk("req_addr_rdy", 32'(req_addr_rdy), 32'(e_rdy));
            chk("mem_addr_vld", 32'(mem_addr_vld), 32'(m_full));
            if (m_full)
                chk("mem_addr", mem_addr, m_addr);
            chk("outstanding", 32'(outstanding), 32'(q.size()));
            chk("req_data_vld", 32'(req_data_vld), 32'(e_dv));
            if (e_dv != '0)
                chk("req_data", req_data, e_d);
            chk("err_unexpected_rsp", 32'(err), 32'(e_err));
        end
        if (rst) begin
            q.delete();
            m_full = 0; m_addr = '0; last = N - 1;
            m_lock = 0; run_len = 0;
            e_dv = '0; e_d = '0; e_err = 0;
        end else begin
            e_dv = '0;
            if (mem_data_vld) begin
                if (q.size() > 0) begin
                    t = q.pop_front();
                    e_dv[t] = 1'b1;
                    e_d = mem_data;
                    rlog.push_back(t);
                    dlog.push_back(mem_data);
                end else begin
                    e_err = 1;
                end
            end
            if (g >= 0) begin
                m_full = 1;
                m_addr = req_addr[32*g +: 32];
                q.push_back(g);
                glog.push_back(g);
                if (m_lock && g == last && run_len < 16) run_len++;
                else run_len = 1;
                m_lock = 1;
                last = g;
            end else begin
                if (mem_addr_rdy) m_full = 0;
                if (free && !req_addr_vld[last]) m_lock = 0;
            end
        end
    end

    // Memory responder: data returns a fixed number of cycles after issue
    int          tcnt = 0;
    bit          resp_en = 0;
    int          due[$];
    logic [31:0] next_d = '0;

    task automatic tick();
        @(negedge clk);
        if (resp_en && mem_addr_vld && mem_addr_rdy)
            due.push_back(tcnt + 4);
        @(posedge clk);
        #1;
        tcnt++;
        if (resp_en) begin
            if (due.size() > 0 && due[0] == tcnt) begin
                mem_data_vld = 1'b1;
                mem_data = next_d;
                next_d++;
                void'(due.pop_front());
            end else begin
                mem_data_vld = 1'b0;
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        resp_en = 0;
        due.delete();
        req_addr_vld = '0;
        mem_addr_rdy = 1'b0;
        mem_data_vld = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    logic [3:0]  exp_oh [6];
    logic [31:0] exp_a  [6];
    int          exp_rl [4];

    initial begin
`ifdef ARB_LOCK_EN
        exp_oh = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
        exp_a  = '{32'h1000_0000, 32'h1000_0000, 32'h1000_0000,
                   32'h1000_0000, 32'h1000_0000, 32'h1000_0000};
        exp_rl = '{0, 0, 0, 0};
`else
        exp_oh = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
        exp_a  = '{32'h1000_0000, 32'h1000_0040, 32'h1000_0080,
                   32'h1000_00c0, 32'h1000_0000, 32'h1000_0040};
        exp_rl = '{0, 1, 2, 3};
`endif
        do_reset();
        #1;
        chk("reset_outstanding", 32'(outstanding), 32'd0);
        chk("reset_mem_addr_vld", 32'(mem_addr_vld), 32'd0);
        chk("reset_err", 32'(err), 32'd0);

        // Unexpected response with nothing outstanding
        mem_data_vld = 1'b1;
        mem_data = 32'hdead_beef;
        tick();
        mem_data_vld = 1'b0;
        #1;
        chk("unexp_err_set", 32'(err), 32'd1);
        chk("unexp_no_data", 32'(req_data_vld), 32'd0);
        chk("unexp_outstanding", 32'(outstanding), 32'd0);
        repeat (3) tick();
        chk("unexp_err_held", 32'(err), 32'd1);

        // All lanes request continuously; memory answers in order
        do_reset();
        rlog.delete();
        dlog.delete();
        mem_addr_rdy = 1'b1;
        resp_en = 1;
        next_d = 32'ha0;
        for (int l = 0; l < N; l++)
            req_addr[32*l +: 32] = 32'h1000_0000 + 32'(l) * 32'h40;
        req_addr_vld = '1;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("rr_grant", 32'(req_addr_rdy), 32'(exp_oh[i]));
            tick();
            chk("rr_mem_addr", mem_addr, exp_a[i]);
        end
        req_addr_vld = '0;
        repeat (10) tick();
        chk("rsp_count", 32'(rlog.size()), 32'd6);
        for (int i = 0; i < 4; i++) begin
            chk("rsp_lane", 32'(rlog[i]), 32'(exp_rl[i]));
            chk("rsp_data", dlog[i], 32'ha0 + 32'(i));
        end

        // Outstanding limit with lane 1 only and no responses
        do_reset();
        mem_addr_rdy = 1'b1;
        req_addr[32 +: 32] = 32'h2000_0000;
        req_addr_vld = 4'b0010;
        repeat (10) tick();
        #1;
        chk("full_outstanding", 32'(outstanding), 32'd8);
        chk("full_rdy", 32'(req_addr_rdy), 32'd0);
        mem_data_vld = 1'b1;
        mem_data = 32'hb0;
        #1;
        chk("pop_cycle_rdy", 32'(req_addr_rdy), 32'd0);
        chk("pop_cycle_outstanding", 32'(outstanding), 32'd8);
        tick();
        mem_data_vld = 1'b0;
        #1;
        chk("after_pop_rdy", 32'(req_addr_rdy), 32'b0010);
        chk("after_pop_outstanding", 32'(outstanding), 32'd7);
        chk("after_pop_data_vld", 32'(req_data_vld), 32'b0010);
        chk("after_pop_data", req_data, 32'hb0);
        tick();
        chk("refill_outstanding", 32'(outstanding), 32'd8);
        req_addr_vld = '0;
        tick();

        // Memory back-pressure holds the address stage
        do_reset();
        req_addr[64 +: 32] = 32'h3000_0010;
        req_addr_vld = 4'b0100;
        tick();
        req_addr[64 +: 32] = 32'h3000_0020;
        repeat (5) begin
            #1;
            chk("stall_mem_addr", mem_addr, 32'h3000_0010);
            chk("stall_rdy", 32'(req_addr_rdy), 32'd0);
            tick();
        end
        mem_addr_rdy = 1'b1;
        #1;
        chk("release_rdy", 32'(req_addr_rdy), 32'b0100);
        tick();
        chk("release_mem_addr", mem_addr, 32'h3000_0020);
        req_addr_vld = '0;
        tick();

        // Lanes 0 and 2 compete
        do_reset();
        glog.delete();
        mem_addr_rdy = 1'b1;
        resp_en = 1;
        next_d = 32'hc0;
        req_addr[0 +: 32]  = 32'h4000_0000;
        req_addr[64 +: 32] = 32'h4200_0000;
        req_addr_vld = 4'b0101;
        repeat (40) tick();
        req_addr_vld = '0;
        repeat (10) tick();
        chk("pair_grants_enough", 32'(glog.size() >= 17), 32'd1);
`ifdef ARB_LOCK_EN
        for (int i = 0; i < 17; i++)
            chk("lock_seq", 32'(glog[i]), (i < 16) ? 32'd0 : 32'd2);
`else
        for (int i = 0; i < 4; i++)
            chk("alt_seq", 32'(glog[i]), (i % 2 == 1) ? 32'd2 : 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sha256_mem_arbiter.md
Name: sha256_mem_arbiter

Overview:
- Shares one memory read port between N_REQ chunk-processor lanes so several SHA-256 contexts can fill chunks concurrently.
- Grants address requests round-robin and forwards them through a registered address stage.
- Records the granted lane ID in an in-order tag FIFO.
- Routes each returning read word to the lane that issued it.

Parameters:
N_REQ, 4, number of requester lanes (2..8)
MAX_OUTSTANDING, 8, max accepted-but-unanswered reads; also the tag FIFO depth (power of 2)

Ports:
clk  input  1  clock
rst  input  1  synchronous, active-high reset
req_addr_vld  input  N_REQ  per-lane read request valid
req_addr  input  N_REQ*32  per-lane byte address; lane i at bits [32*i+31:32*i]
req_addr_rdy  output  N_REQ  per-lane accept; at most one bit high per cycle
req_data_vld  output  N_REQ  per-lane read-data valid; one-hot or zero
req_data  output  32  read data, broadcast to all lanes
mem_addr_vld  output  1  request to memory
mem_addr_rdy  input  1  memory accepts request
mem_addr  output  32  address to memory
mem_data_vld  input  1  memory read data valid; responses return in issue order
mem_data  input  32  memory read data
outstanding  output  $clog2(MAX_OUTSTANDING)+1  current outstanding count
err_unexpected_rsp  output  1  sticky: mem_data_vld seen with tag FIFO empty

Behaviour:
- Reset values: all outputs 0. Round-robin pointer resets to lane 0, so lane 0 has highest priority first. Tag FIFO is emptied; rst mid-operation drops all in-flight tags.
- Address stage is a single output register (addr_full, mem_addr, mem_addr_vld = addr_full).
  - Stage is free when !addr_full || mem_addr_rdy.
  - Grant is allowed only when the stage is free and outstanding < MAX_OUTSTANDING.
  - Otherwise all req_addr_rdy are 0.
- Arbitration is combinational within the cycle.
  - Scan starts at lane (last_grant+1) mod N_REQ; the first lane with req_addr_vld=1 gets req_addr_rdy=1.
  - req_addr_rdy never depends combinationally on req_addr.
- Accept on (req_addr_vld[i] & req_addr_rdy[i]), same cycle:
  - load req_addr[i] into mem_addr;
  - set addr_full;
  - push tag i into the FIFO;
  - set last_grant=i.
- Latency: accept in cycle N gives mem_addr_vld=1 in cycle N+1. The stage holds until mem_addr_rdy. Back-to-back accepts sustain 1 request/cycle when mem_addr_rdy=1.
- outstanding:
  - +1 on accept, −1 on a matched mem_data_vld.
  - Both in the same cycle leaves it unchanged.
  - It counts requests still held in the address stage.
- Response path:
  - On mem_data_vld with FIFO non-empty: pop head tag t.
  - Next cycle: req_data_vld[t]=1 and req_data=mem_data (1-cycle registered latency).
  - req_data_vld is 0 in all other cycles.
- Unexpected response (mem_data_vld with FIFO empty):
  - data dropped, no req_data_vld;
  - err_unexpected_rsp set and held until rst;
  - outstanding stays 0, never underflows.
- Full boundary: with outstanding == MAX_OUTSTANDING, no grant occurs that cycle, even if a response pops in the same cycle. Grant may resume the following cycle.
- Lane deasserting req_addr_vld without handshake: no effect; arbitration resumes with the other lanes.

Optional Feature:
ARB_LOCK_EN
- Defined: after a grant to lane i, lane i keeps priority while req_addr_vld[i] stays 1.
  - Consecutive accepts go to lane i, so a chunk fill is issued contiguously.
  - Lock releases the first cycle req_addr_vld[i]=0 during a free-stage cycle, or after 16 consecutive grants to lane i (fairness cap); scan then resumes from i+1.
- Undefined: pure per-request round-robin as above.

Test Plan:
- Reset; then lanes 0..3 all request continuously, mem_addr_rdy=1 -> grant order 0,1,2,3,0,1…; each mem_addr equals the granted lane's req_addr one cycle after its accept.
- Memory returns data 0xA0..0xA3 in order, 3 cycles after each issue -> req_data_vld one-hot 0,1,2,3 with req_data 0xA0..0xA3, each 1 cycle after its mem_data_vld.
- mem_data_vld held 0; lane 1 issues 8 reads -> outstanding reaches 8 and req_addr_rdy stays 0. Single response pops -> outstanding stays 8 that cycle; grant occurs the next cycle.
- mem_addr_rdy=0 for 5 cycles with a request in the stage -> mem_addr stable, no new grants. On release, next grant occurs the same cycle.
- mem_data_vld=1 after reset with no requests -> err_unexpected_rsp=1 and held, all req_data_vld=0, outstanding=0.
- ARB_LOCK_EN defined, lanes 0 and 2 request continuously -> 16 consecutive grants to lane 0, then lane 2. Undefined -> grants alternate 0,2,0,2.
